csr_regfile: RTL

- Machine-mode control and status register file, directly downstream of the CSR execute stage.
- Consumes the execute stage's write request: csr_out_en, csrw_addr, csrw_data.
- Returns the current CSR value on csr_data through a combinational read port, for read-modify-write in execute.
- Also holds the cycle/instret counters and the trap-entry/mret state updates that the pipeline control uses.

---
 rtl/csr_regfile.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/csr_regfile.sv
// rtl/csr_regfile.sv - machine-mode CSR file with cycle/instret counters and trap/mret state
module csr_regfile #(
  parameter int unsigned      XLEN      = 32,
  parameter logic [XLEN-1:0]  MISA_VAL  = 32'h40000100,
  parameter logic [XLEN-1:0]  MTVEC_RST = 32'h00000000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [11:0]     csr_raddr,
  output logic [XLEN-1:0] csr_data,
  input  logic            csr_out_en,
  input  logic [11:0]     csrw_addr,
  input  logic [XLEN-1:0] csrw_data,
  input  logic            instret_en,
  input  logic            trap_en,
  input  logic [XLEN-1:0] trap_pc,
  input  logic [XLEN-1:0] trap_cause,
  input  logic [XLEN-1:0] trap_val,
  input  logic            mret_en,
  output logic [XLEN-1:0] mtvec_out,
  output logic [XLEN-1:0] mepc_out,
  output logic            mie_global
);

  localparam logic [11:0] A_MSTATUS   = 12'h300;
  localparam logic [11:0] A_MISA      = 12'h301;
  localparam logic [11:0] A_MIE       = 12'h304;
  localparam logic [11:0] A_MTVEC     = 12'h305;
  localparam logic [11:0] A_MSCRATCH  = 12'h340;
  localparam logic [11:0] A_MEPC      = 12'h341;
  localparam logic [11:0] A_MCAUSE    = 12'h342;
  localparam logic [11:0] A_MTVAL     = 12'h343;
  localparam logic [11:0] A_MIP       = 12'h344;
  localparam logic [11:0] A_MCYCLE    = 12'hB00;
  localparam logic [11:0] A_MCYCLEH   = 12'hB80;
  localparam logic [11:0] A_MINSTRET  = 12'hB02;
  localparam logic [11:0] A_MINSTRETH = 12'hB82;
  localparam logic [11:0] A_CYCLE     = 12'hC00;
  localparam logic [11:0] A_CYCLEH    = 12'hC80;
  localparam logic [11:0] A_INSTRET   = 12'hC02;
  localparam logic [11:0] A_INSTRETH  = 12'hC82;

  logic              r_mie_bit;
  logic              r_mpie_bit;
  logic [XLEN-1:0]   r_mie;
  logic [XLEN-1:0]   r_mtvec;
  logic [XLEN-1:0]   r_mscratch;
  logic [XLEN-1:0]   r_mepc;
  logic [XLEN-1:0]   r_mcause;
  logic [XLEN-1:0]   r_mtval;
  logic [2*XLEN-1:0] r_mcycle;
  logic [2*XLEN-1:0] r_minstret;

  logic [XLEN-1:0]   w_mstatus;
  logic              w_sys_event;
  logic              w_wr_mstatus;
  logic              w_wr_mie;
  logic              w_wr_mtvec;
  logic              w_wr_mscratch;
  logic              w_wr_mepc;
  logic              w_wr_mcause;
  logic              w_wr_mtval;
  logic              w_wr_cyc_lo;
  logic              w_wr_cyc_hi;
  logic              w_wr_ret_lo;
  logic              w_wr_ret_hi;

  always_comb begin
    w_mstatus        = '0;
    w_mstatus[12:11] = 2'b11;
    w_mstatus[7]     = r_mpie_bit;
    w_mstatus[3]     = r_mie_bit;
  end

  // Trap/mret own mstatus/mepc/mcause/mtval that cycle; other CSR writes still land.
  assign w_sys_event   = trap_en | mret_en;
  assign w_wr_mstatus  = csr_out_en && (csrw_addr == A_MSTATUS) && !w_sys_event;
  assign w_wr_mepc     = csr_out_en && (csrw_addr == A_MEPC)    && !w_sys_event;
  assign w_wr_mcause   = csr_out_en && (csrw_addr == A_MCAUSE)  && !w_sys_event;
  assign w_wr_mtval    = csr_out_en && (csrw_addr == A_MTVAL)   && !w_sys_event;
  assign w_wr_mie      = csr_out_en && (csrw_addr == A_MIE);
  assign w_wr_mtvec    = csr_out_en && (csrw_addr == A_MTVEC);
  assign w_wr_mscratch = csr_out_en && (csrw_addr == A_MSCRATCH);
  assign w_wr_cyc_lo   = csr_out_en && (csrw_addr == A_MCYCLE);
  assign w_wr_cyc_hi   = csr_out_en && (csrw_addr == A_MCYCLEH);
  assign w_wr_ret_lo   = csr_out_en && (csrw_addr == A_MINSTRET);
  assign w_wr_ret_hi   = csr_out_en && (csrw_addr == A_MINSTRETH);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mie_bit  <= 1'b0;
      r_mpie_bit <= 1'b0;
    end else if (trap_en) begin
      r_mpie_bit <= r_mie_bit;
      r_mie_bit  <= 1'b0;
    end else if (mret_en) begin
      r_mie_bit  <= r_mpie_bit;
      r_mpie_bit <= 1'b1;
    end else if (w_wr_mstatus) begin
      r_mie_bit  <= csrw_data[3];
      r_mpie_bit <= csrw_data[7];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mepc   <= '0;
      r_mcause <= '0;
      r_mtval  <= '0;
    end else if (trap_en) begin
      r_mepc   <= {trap_pc[XLEN-1:2], 2'b00};
      r_mcause <= trap_cause;
      r_mtval  <= trap_val;
    end else begin
      if (w_wr_mepc)   r_mepc   <= {csrw_data[XLEN-1:2], 2'b00};
      if (w_wr_mcause) r_mcause <= csrw_data;
      if (w_wr_mtval)  r_mtval  <= csrw_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mie      <= '0;
      r_mtvec    <= MTVEC_RST;
      r_mscratch <= '0;
    end else begin
      if (w_wr_mie)      r_mie      <= csrw_data;
      if (w_wr_mtvec)    r_mtvec    <= {csrw_data[XLEN-1:2], 2'b00};
      if (w_wr_mscratch) r_mscratch <= csrw_data;
    end
  end

  // A software write freezes the other half for that cycle: no increment, no carry.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mcycle <= '0;
    end else if (w_wr_cyc_lo) begin
      r_mcycle[XLEN-1:0] <= csrw_data;
    end else if (w_wr_cyc_hi) begin
      r_mcycle[2*XLEN-1:XLEN] <= csrw_data;
    end else begin
      r_mcycle <= r_mcycle + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_minstret <= '0;
    end else if (w_wr_ret_lo) begin
      r_minstret[XLEN-1:0] <= csrw_data;
    end else if (w_wr_ret_hi) begin
      r_minstret[2*XLEN-1:XLEN] <= csrw_data;
    end else if (instret_en) begin
      r_minstret <= r_minstret + 1'b1;
    end
  end

  always_comb begin
    csr_data = '0;
    case (csr_raddr)
      A_MSTATUS:               csr_data = w_mstatus;
      A_MISA:                  csr_data = MISA_VAL;
      A_MIE:                   csr_data = r_mie;
      A_MTVEC:                 csr_data = r_mtvec;
      A_MSCRATCH:              csr_data = r_mscratch;
      A_MEPC:                  csr_data = r_mepc;
      A_MCAUSE:                csr_data = r_mcause;
      A_MTVAL:                 csr_data = r_mtval;
      A_MIP:                   csr_data = '0;
      A_MCYCLE,   A_CYCLE:     csr_data = r_mcycle[XLEN-1:0];
      A_MCYCLEH,  A_CYCLEH:    csr_data = r_mcycle[2*XLEN-1:XLEN];
      A_MINSTRET, A_INSTRET:   csr_data = r_minstret[XLEN-1:0];
      A_MINSTRETH, A_INSTRETH: csr_data = r_minstret[2*XLEN-1:XLEN];
      default:                 csr_data = '0;
    endcase
  end

  assign mtvec_out  = r_mtvec;
  assign mepc_out   = r_mepc;
  assign mie_global = r_mie_bit;

endmodule
